// File: rtl/fifo_n_pipelined_if.sv
// Guarded-method enq/deq/first bundle plus occupancy status for fifo_n_pipelined.
// The user side is the master modport; the FIFO is the slave.
interface fifo_n_pipelined_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_enq__ENA;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out_deq__ENA;
  logic             out_deq__RDY;
  logic [WIDTH-1:0] out_first;
  logic             out_first__RDY;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    output in_enq__ENA, in_enq_v, out_deq__ENA,
    input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, count, full, empty
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out_deq__ENA,
    output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, count, full, empty
  );
endinterface

// File: rtl/fifo_n_pipelined.sv
// Circular-buffer FIFO, DEPTH x WIDTH, head readable combinationally; enq visible one cycle later.
// PIPELINED=1 lets enq fire into a full FIFO when deq fires too (comb path out_deq__ENA -> in_enq__RDY).
module fifo_n_pipelined #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int PIPELINED = 0
) (
  input logic               CLK,
  input logic               RST,
  fifo_n_pipelined_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_enq_rdy;
  logic w_deq_rdy;
  logic w_enq_fire;
  logic w_deq_fire;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_deq_rdy = !w_empty;

  generate
    if (PIPELINED != 0) begin : g_pipe
      assign w_enq_rdy = !w_full || (io.out_deq__ENA && !w_empty);
    end else begin : g_nopipe
      assign w_enq_rdy = !w_full;
    end
  endgenerate

  assign w_enq_fire = io.in_enq__ENA && w_enq_rdy;
  assign w_deq_fire = io.out_deq__ENA && w_deq_rdy;

  // When full and both fire, wr_ptr == rd_ptr: the freed head slot takes the new data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_enq_fire) begin
        r_mem[r_wr_ptr] <= io.in_enq_v;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign io.in_enq__RDY    = w_enq_rdy;
  assign io.out_deq__RDY   = w_deq_rdy;
  assign io.out_first__RDY = w_deq_rdy;
  assign io.out_first      = r_mem[r_rd_ptr];
  assign io.count          = r_count;
  assign io.full           = w_full;
  assign io.empty          = w_empty;
endmodule

// File: tb/tb_fifo_n_pipelined.sv
// Drives identical stimulus into a PIPELINED=0 and a PIPELINED=1 instance; a queue
// scoreboard per instance is filled on predicted enqueues and drained by a deq monitor.
module tb_fifo_n_pipelined;
  localparam int W = 64;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fifo_n_pipelined_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  fifo_n_pipelined_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  fifo_n_pipelined #(.WIDTH(W), .DEPTH(D), .PIPELINED(0)) u0 (.CLK(CLK), .RST(RST), .io(if0));
  fifo_n_pipelined #(.WIDTH(W), .DEPTH(D), .PIPELINED(1)) u1 (.CLK(CLK), .RST(RST), .io(if1));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];
  int           mc[2];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] status(input int p);
    if (p == 0)
      return {if0.in_enq__RDY, if0.out_deq__RDY, if0.out_first__RDY, if0.full, if0.empty, if0.count};
    else
      return {if1.in_enq__RDY, if1.out_deq__RDY, if1.out_first__RDY, if1.full, if1.empty, if1.count};
  endfunction

  task automatic drive(input bit e, input logic [W-1:0] d, input bit q);
    if0.in_enq__ENA = e; if0.in_enq_v = d; if0.out_deq__ENA = q;
    if1.in_enq__ENA = e; if1.in_enq_v = d; if1.out_deq__ENA = q;
  endtask

  // One clock of stimulus; the model predicts readiness and occupancy from the queue depth.
  task automatic step(input bit e, input logic [W-1:0] d, input bit q);
    bit er, ef, df;
    logic [7:0] exp_st;
    drive(e, d, q);
    @(negedge CLK);
    for (int p = 0; p < 2; p++) begin
      er = (mc[p] < D) || (p == 1 && q && mc[p] > 0);
      ef = e && er;
      df = q && (mc[p] > 0);
      exp_st = {er, mc[p] > 0, mc[p] > 0, mc[p] == D, mc[p] == 0, 3'(mc[p])};
      chk($sformatf("status%0d", p), W'(status(p)), W'(exp_st));
      if (ef) begin
        if (p == 0) sb0.push_back(d);
        else        sb1.push_back(d);
      end
      mc[p] = mc[p] + int'(ef) - int'(df);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit e, input logic [W-1:0] d, input bit q);
    drive(e, d, q);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb0.delete();
    sb1.delete();
    mc[0] = 0;
    mc[1] = 0;
    chk("rst_first0", if0.out_first, '0);
    chk("rst_first1", if1.out_first, '0);
    chk("rst_status0", W'(status(0)), W'(8'b1000_1000));
    chk("rst_status1", W'(status(1)), W'(8'b1000_1000));
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (if0.out_deq__ENA && if0.out_deq__RDY) begin
        if (sb0.size() == 0) chk("underflow0", 1, 0);
        else                 chk("deq_data0", if0.out_first, sb0.pop_front());
      end
      if (if1.out_deq__ENA && if1.out_deq__RDY) begin
        if (sb1.size() == 0) chk("underflow1", 1, 0);
        else                 chk("deq_data1", if1.out_first, sb1.pop_front());
      end
      chk("inv_bounds0", W'(if0.count <= 3'(D) && !(if0.full && if0.empty)), 1);
      chk("inv_bounds1", W'(if1.count <= 3'(D) && !(if1.full && if1.empty)), 1);
      chk("inv_ptr0", W'(2'(u0.r_wr_ptr - u0.r_rd_ptr)), W'(if0.count[1:0]));
      chk("inv_ptr1", W'(2'(u1.r_wr_ptr - u1.r_rd_ptr)), W'(if1.count[1:0]));
    end
  end

  initial begin
    mc[0] = 0;
    mc[1] = 0;
    drive(0, '0, 0);
    repeat (2) @(posedge CLK);
    #1;
    // Reset then idle; deq pulses on an empty FIFO change nothing.
    do_reset(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);

    // Fill to full, then a dropped enq.
    step(1, 64'h11, 0);
    step(1, 64'h22, 0);
    step(1, 64'h33, 0);
    step(1, 64'h44, 0);
    step(1, 64'h55, 0);
    chk("head_full0", if0.out_first, 64'h11);
    chk("head_full1", if1.out_first, 64'h11);

    // Drain, then pointer-wrap with enq/deq pairs.
    repeat (4) step(0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, {$urandom, $urandom}, 0);
      step(0, '0, 1);
    end

    // Simultaneous enq+deq at count=2.
    do_reset(0, '0, 0);
    step(1, 64'hA, 0);
    step(1, 64'hB, 0);
    step(1, 64'hC, 1);
    chk("simul_head0", if0.out_first, 64'hB);
    chk("simul_head1", if1.out_first, 64'hB);
    step(0, '0, 1);
    step(0, '0, 1);

    // Full with enq+deq: pipelined accepts, non-pipelined drops.
    do_reset(0, '0, 0);
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0);
    step(1, 64'h5, 1);
    chk("full_simul_cnt0", W'(if0.count), 3);
    chk("full_simul_cnt1", W'(if1.count), 4);
    repeat (5) step(0, '0, 1);

    // Reset mid-stream with enq active.
    do_reset(0, '0, 0);
    step(1, 64'h1, 0);
    step(1, 64'h2, 0);
    step(1, 64'h3, 0);
    do_reset(1, 64'h99, 1);
    step(1, 64'h77, 0);
    chk("post_rst_head0", if0.out_first, 64'h77);
    chk("post_rst_head1", if1.out_first, 64'h77);
    step(0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 1'($urandom_range(0, 99) < 50));
    end
    repeat (6) step(0, '0, 1);
    chk("final_sb0", W'(sb0.size()), 0);
    chk("final_sb1", W'(sb1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
